mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between the IF-stage fetch port and the MEM-stage load/store

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the IF fetch port and the MEM-stage
//   load/store port. One transaction is in flight at a time. The data port wins
//   ties, but after STARVE_LIMIT back-to-back data grants with a fetch waiting,
//   the fetch is forced through. A watchdog aborts a hung memory access after
//   TIMEOUT cycles and returns rdata=0 with err=1, so the pipeline never
//   deadlocks.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (held until if_valid)
//   if_rdata/if_valid     fetch response, one-cycle valid pulse
//   if_stall              if_req & ~if_valid
//   dm_req/we/addr/wdata/be  load/store request (held until dm_valid)
//   dm_rdata/dm_valid     data response, one-cycle valid pulse
//   dm_stall              dm_req & ~dm_valid
//   err                   pulses with the valid of a timed-out transaction
//   mem_req/we/addr/wdata/be  registered memory request, held until mem_ready
//   mem_ready/mem_rvalid/mem_rdata  memory accept / completion / read data
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;       // 1 = data port, 0 = fetch port
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;

  logic          starved;
  logic          timed_out;

  assign starved   = (starve_cnt_q >= SW'(STARVE_LIMIT));
  // timer_q holds the number of ISSUE/WAIT cycles already spent, so this is
  // the TIMEOUT-th such cycle.
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    starve_cnt_d = starve_cnt_q;
    timer_d      = timer_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        err_d   = 1'b0;
        if (dm_req && (!if_req || !starved)) begin
          owner_d     = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_we ? dm_be : 4'hF;
          if (if_req && !starved) starve_cnt_d = starve_cnt_q + 1'b1;
          state_d     = S_ISSUE;
        end else if (if_req) begin
          owner_d      = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = 4'hF;
          starve_cnt_d = '0;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A completion always beats the watchdog in the same cycle.
        if (mem_rvalid && (state_q == S_WAIT || mem_ready)) begin
          if (owner_q) dm_rdata_d = mem_rdata;
          else         if_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (timed_out) begin
          if (owner_q) dm_rdata_d = '0;
          else         if_rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (state_q == S_ISSUE && mem_ready) begin
          state_d = S_WAIT;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      starve_cnt_q <= '0;
      timer_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      starve_cnt_q <= starve_cnt_d;
      timer_q      <= timer_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  assign if_valid  = (state_q == S_RESP) && !owner_q;
  assign dm_valid  = (state_q == S_RESP) &&  owner_q;
  assign err       = (state_q == S_RESP) &&  err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus and checks happen on the
// falling edge; a small memory responder reacts just after each rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid, dm_stall, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  // responder controls (written only by the test sequence)
  int          ready_delay = 0;
  bit          rv_en = 1'b1;
  bit          force_rv = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;
  // responder state
  int          wait_cnt = 0;
  bit          pend = 1'b0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: accepts after ready_delay cycles of mem_req, completes the cycle
  // after acceptance. Read data is either fixed or {A5A5, addr[15:0]}.
  always @(posedge clk) begin
    #1;
    mem_rvalid = (pend && rv_en) || force_rv;
    mem_rdata  = use_fixed ? fixed_rdata : {16'hA5A5, mem_addr[15:0]};
    pend       = 1'b0;
    mem_ready  = 1'b0;
    if (mem_req && !rst) begin
      if (wait_cnt == ready_delay) begin
        mem_ready = 1'b1;
        pend      = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 70'd0) begin
      bad++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h be=%h want all 0",
                      mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    total++;
    if ({if_valid, dm_valid, err} !== 3'b000) begin
      bad++; $display("FAIL reset_valid: got %b want 000", {if_valid, dm_valid, err});
    end
    total++;
    if ({if_rdata, dm_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, dm_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task test_fetch_only;
    use_fixed = 1'b1; fixed_rdata = 32'h00500093; ready_delay = 0; rv_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk); // cycle 1
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0}) begin
      bad++; $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h want 1 0 f 0",
                      mem_req, mem_we, mem_be, mem_addr);
    end
    total++;
    if (if_stall !== 1'b1) begin
      bad++; $display("FAIL fetch_stall: got %b want 1", if_stall);
    end
    @(negedge clk); // cycle 2
    total++;
    if ({mem_req, if_valid} !== 2'b00) begin
      bad++; $display("FAIL fetch_wait: got req=%b valid=%b want 0 0", mem_req, if_valid);
    end
    @(negedge clk); // cycle 3
    total++;
    if ({if_valid, dm_valid, err, if_stall} !== 4'b1000) begin
      bad++; $display("FAIL fetch_resp: got v=%b dv=%b err=%b stall=%b want 1 0 0 0",
                      if_valid, dm_valid, err, if_stall);
    end
    total++;
    if (if_rdata !== 32'h00500093) begin
      bad++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk); // cycle 4
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL fetch_pulse: got %b want 0", if_valid);
    end
    use_fixed = 1'b0;
  endtask

  task test_priority;
    int dm_cyc, if_cyc, both;
    logic [31:0] dm_rd, if_rd;
    dm_cyc = -1; if_cyc = -1; both = 0; dm_rd = '0; if_rd = '0;
    if_req = 1'b1; if_addr = 32'h4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_be = 4'hF; dm_wdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if ({dm_stall, if_stall} !== 2'b11) begin
          bad++; $display("FAIL prio_stall: got dm=%b if=%b want 1 1", dm_stall, if_stall);
        end
      end
      if (if_valid && dm_valid) both++;
      if (dm_valid && dm_cyc < 0) begin dm_cyc = c; dm_rd = dm_rdata; dm_req = 1'b0; end
      if (if_valid && if_cyc < 0) begin if_cyc = c; if_rd = if_rdata; if_req = 1'b0; end
    end
    total++;
    if (dm_cyc != 3 || if_cyc != 7) begin
      bad++; $display("FAIL prio_order: got dm_cycle=%0d if_cycle=%0d want 3 7", dm_cyc, if_cyc);
    end
    total++;
    if (dm_rd !== 32'hA5A50100) begin
      bad++; $display("FAIL prio_dm_rdata: got %h want a5a50100", dm_rd);
    end
    total++;
    if (if_rd !== 32'hA5A50004) begin
      bad++; $display("FAIL prio_if_rdata: got %h want a5a50004", if_rd);
    end
    total++;
    if (both != 0) begin
      bad++; $display("FAIL prio_overlap: got %0d cycles with both valids want 0", both);
    end
  endtask

  task test_starvation;
    logic [9:0] seq;
    int n;
    seq = '0; n = 0;
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (n < 10 && (if_valid || dm_valid)) begin
        seq = {seq[8:0], dm_valid};
        n++;
        if (n == 10) begin if_req = 1'b0; dm_req = 1'b0; end
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    total++;
    if (n != 10) begin
      bad++; $display("FAIL starve_count: got %0d completions want 10", n);
    end
    // two rounds of 4 data grants then a forced fetch: the counter restarts
    total++;
    if (seq !== 10'b1111011110) begin
      bad++; $display("FAIL starve_order: got %b want 1111011110", seq);
    end
  endtask

  task test_store_wait;
    int vcyc, pulses;
    vcyc = -1; pulses = 0;
    ready_delay = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !==
            {1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011}) begin
          bad++; $display("FAIL store_hold c%0d: got req=%b we=%b addr=%h wdata=%h be=%b want 1 1 200 deadbeef 0011",
                          c, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
      end
      if (c == 5) begin
        total++;
        if (mem_req !== 1'b0) begin
          bad++; $display("FAIL store_release: got mem_req=%b want 0", mem_req);
        end
      end
      if (dm_valid) begin
        pulses++;
        if (vcyc < 0) begin vcyc = c; dm_req = 1'b0; end
      end
    end
    total++;
    if (vcyc != 6 || pulses != 1) begin
      bad++; $display("FAIL store_valid: got cycle=%0d pulses=%0d want 6 1", vcyc, pulses);
    end
    dm_we = 1'b0; ready_delay = 0;
  endtask

  task test_timeout;
    int vc, extra;
    logic e, tail;
    logic [31:0] rd;
    vc = -1; extra = 0; e = 1'b0; rd = 32'hFFFF_FFFF; tail = 1'b1;
    rv_en = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_be = 4'hF;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (dm_valid || if_valid) begin
        if (vc < 0) begin vc = c; e = err; rd = dm_rdata; dm_req = 1'b0; end
        else extra++;
      end
      if (c == 66) tail = mem_req | err;
    end
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dm_valid || if_valid) extra++;
    end
    total++;
    if (vc != 65) begin
      bad++; $display("FAIL timeout_cycle: got %0d want 65", vc);
    end
    total++;
    if ({e, rd} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL timeout_resp: got err=%b rdata=%h want 1 0", e, rd);
    end
    total++;
    if (tail !== 1'b0) begin
      bad++; $display("FAIL timeout_after: got mem_req|err=%b want 0", tail);
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL timeout_late_rvalid: got %0d extra valids want 0", extra);
    end
    rv_en = 1'b1;
  endtask

  task test_reset_mid;
    int extra, fc;
    extra = 0; fc = -1;
    rv_en = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_be = 4'hF;
    @(negedge clk); // cycle 1: ISSUE
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL rstmid_issue: got mem_req=%b want 1", mem_req);
    end
    @(negedge clk); // cycle 2: WAIT
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk); // cycle 3: after reset edge
    rst = 1'b0;
    total++;
    if ({mem_req, dm_valid, if_valid, err, mem_addr} !== 36'd0) begin
      bad++; $display("FAIL rstmid_idle: got req=%b dv=%b iv=%b err=%b addr=%h want all 0",
                      mem_req, dm_valid, if_valid, err, mem_addr);
    end
    force_rv = 1'b1;
    @(negedge clk);
    force_rv = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dm_valid || if_valid || mem_req) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", extra);
    end
    // the port must be usable again after the abort
    rv_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_valid && fc < 0) begin
        fc = c; if_req = 1'b0;
        total++;
        if (if_rdata !== 32'hA5A50040) begin
          bad++; $display("FAIL rstmid_recover_data: got %h want a5a50040", if_rdata);
        end
      end
    end
    if_req = 1'b0;
    total++;
    if (fc != 3) begin
      bad++; $display("FAIL rstmid_recover: got valid cycle %0d want 3", fc);
    end
  endtask

  initial begin
    test_reset;
    test_fetch_only;
    test_priority;
    test_starvation;
    test_store_wait;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
